bus_cycle_sequencer: RTL and testbench

- Multi-cycle bus sequencer sitting directly downstream of the CPU-side bus interface, between it and the memory/peripheral bus.
- Registers one word-aligned request (address[31:2], data, byte strobes, direction) and drives the external bus for a programmable number of wait states, then until the device acknowledges.
- Returns latched read data and a one-cycle done/error completion to the core. While an access is in flight it holds the core with busy.

---
 rtl/bus_cycle_sequencer.sv | 155 +++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: registers one word-aligned CPU request, drives the
// memory/peripheral bus for WAIT_STATES cycles and then until mem_ready,
// and returns read data plus a one-cycle done/error completion.
// Optional feature: define BUS_TIMEOUT_EN to build a watchdog that faults
// an access after TIMEOUT cycles of mem_ready low past the wait states.
module bus_cycle_sequencer #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] req_address,
    input  logic [31:0] req_data_out,
    input  logic [3:0]  req_data_strobes,
    input  logic        req_bus_error,
    input  logic        req_read,
    input  logic        req_write,
    output logic [31:0] req_data_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [29:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic [3:0]  mem_strobes,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2,
        FAULT    = 2'd3
    } state_t;

    // Reject out-of-range configurations at elaboration time.
    if (WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("bus_cycle_sequencer: WAIT_STATES must be 0..15 and TIMEOUT 1..255");
    end

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [29:0] mem_address_reg;
    logic [31:0] mem_data_out_reg;
    logic [3:0]  mem_strobes_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [31:0] req_data_in_reg;
    logic        done_reg;
    logic        error_reg;
`ifdef BUS_TIMEOUT_EN
    logic [7:0]  timeout_cnt_reg;
`endif

    // Sequencer FSM: all bus strobes and completion pulses are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            wait_cnt_reg     <= 4'd0;
            mem_address_reg  <= 30'd0;
            mem_data_out_reg <= 32'hffff_ffff;
            mem_strobes_reg  <= 4'd0;
            mem_read_reg     <= 1'b0;
            mem_write_reg    <= 1'b0;
            req_data_in_reg  <= 32'hffff_ffff;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            timeout_cnt_reg  <= 8'd0;
`endif
        end else begin
            // Completion pulses last a single cycle unless re-armed below.
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_read || req_write) begin
                        if ((req_read && req_write) || req_bus_error) begin
                            // Malformed request: never touch the bus.
                            state_reg <= FAULT;
                            error_reg <= 1'b1;
                        end else begin
                            mem_address_reg  <= req_address;
                            mem_data_out_reg <= req_data_out;
                            mem_strobes_reg  <= req_data_strobes;
                            mem_read_reg     <= req_read;
                            mem_write_reg    <= req_write;
                            wait_cnt_reg     <= WAIT_STATES[3:0];
`ifdef BUS_TIMEOUT_EN
                            timeout_cnt_reg  <= 8'd0;
`endif
                            state_reg        <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt_reg != 4'd0) begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end else if (mem_ready) begin
                        // Ready is checked before the watchdog so a late ack still wins.
                        if (mem_read_reg) begin
                            req_data_in_reg <= mem_data_in;
                        end
                        mem_read_reg     <= 1'b0;
                        mem_write_reg    <= 1'b0;
                        mem_strobes_reg  <= 4'd0;
                        mem_data_out_reg <= 32'hffff_ffff;
                        done_reg         <= 1'b1;
                        state_reg        <= COMPLETE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (timeout_cnt_reg == TIMEOUT[7:0]) begin
                        mem_read_reg    <= 1'b0;
                        mem_write_reg   <= 1'b0;
                        mem_strobes_reg <= 4'd0;
                        error_reg       <= 1'b1;
                        state_reg       <= FAULT;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
                    end
`endif
                end
                COMPLETE: begin
                    state_reg <= IDLE;
                end
                FAULT: begin
                    mem_read_reg    <= 1'b0;
                    mem_write_reg   <= 1'b0;
                    mem_strobes_reg <= 4'd0;
                    state_reg       <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Stall the core while a request waits to be accepted or is on the bus.
    always_comb begin
        busy = !reset && (((state_reg == IDLE) && (req_read || req_write)) || (state_reg == ACCESS));
    end

    assign req_data_in  = req_data_in_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign mem_address  = mem_address_reg;
    assign mem_data_out = mem_data_out_reg;
    assign mem_strobes  = mem_strobes_reg;
    assign mem_read     = mem_read_reg;
    assign mem_write    = mem_write_reg;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer: a transaction-level model
// is compared against the DUT every cycle, plus literal checks of the
// directed scenarios (read, delayed write, error requests, timeout, reset).
module tb_bus_cycle_sequencer;

    localparam int WS = 1;
    localparam int TO = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] req_address = '0;
    logic [31:0] req_data_out = '0;
    logic [3:0]  req_data_strobes = '0;
    logic        req_bus_error = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_data_in;
    logic        busy, done, error;
    logic [29:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in = '0;
    logic [3:0]  mem_strobes;
    logic        mem_read, mem_write;
    logic        mem_ready = 1'b0;

    always #5 clock = ~clock;

    bus_cycle_sequencer #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_address(req_address), .req_data_out(req_data_out),
        .req_data_strobes(req_data_strobes), .req_bus_error(req_bus_error),
        .req_read(req_read), .req_write(req_write),
        .req_data_in(req_data_in), .busy(busy), .done(done), .error(error),
        .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in), .mem_strobes(mem_strobes),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // An access is "active" from acceptance until ready is honoured; it counts
    // elapsed wait cycles and stalled cycles upward.  A pulse cycle follows.
    logic [29:0] e_mem_address;
    logic [31:0] e_mem_data_out, e_req_data_in;
    logic [3:0]  e_mem_strobes;
    bit          e_mem_read, e_mem_write, e_done, e_error;
    bit          m_active;
    int          m_waited, m_stalled;

    always @(posedge clock) begin
        if (reset) begin
            e_mem_address  <= '0;
            e_mem_data_out <= 32'hffff_ffff;
            e_req_data_in  <= 32'hffff_ffff;
            e_mem_strobes  <= '0;
            e_mem_read     <= 1'b0;
            e_mem_write    <= 1'b0;
            e_done         <= 1'b0;
            e_error        <= 1'b0;
            m_active       <= 1'b0;
            m_waited       <= 0;
            m_stalled      <= 0;
        end else begin
            e_done  <= 1'b0;
            e_error <= 1'b0;
            if (e_done || e_error) begin
                // pulse cycle: requests ignored, back to idle
            end else if (m_active) begin
                if (m_waited < WS) begin
                    m_waited <= m_waited + 1;
                end else if (mem_ready) begin
                    if (e_mem_read) e_req_data_in <= mem_data_in;
                    e_mem_read     <= 1'b0;
                    e_mem_write    <= 1'b0;
                    e_mem_strobes  <= '0;
                    e_mem_data_out <= 32'hffff_ffff;
                    e_done         <= 1'b1;
                    m_active       <= 1'b0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (m_stalled == TO) begin
                    e_mem_read    <= 1'b0;
                    e_mem_write   <= 1'b0;
                    e_mem_strobes <= '0;
                    e_error       <= 1'b1;
                    m_active      <= 1'b0;
                end
`endif
                else begin
                    m_stalled <= m_stalled + 1;
                end
            end else if (req_read || req_write) begin
                if ((req_read && req_write) || req_bus_error) begin
                    e_error <= 1'b1;
                end else begin
                    e_mem_address  <= req_address;
                    e_mem_data_out <= req_data_out;
                    e_mem_strobes  <= req_data_strobes;
                    e_mem_read     <= req_read;
                    e_mem_write    <= req_write;
                    m_active       <= 1'b1;
                    m_waited       <= 0;
                    m_stalled      <= 0;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clock) begin
        if (check_en) begin
            chk("mem_address", {2'b00, mem_address}, {2'b00, e_mem_address});
            chk("mem_data_out", mem_data_out, e_mem_data_out);
            chk("mem_strobes", {28'd0, mem_strobes}, {28'd0, e_mem_strobes});
            chk("mem_read", {31'd0, mem_read}, {31'd0, e_mem_read});
            chk("mem_write", {31'd0, mem_write}, {31'd0, e_mem_write});
            chk("req_data_in", req_data_in, e_req_data_in);
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("error", {31'd0, error}, {31'd0, e_error});
            chk("busy", {31'd0, busy},
                {31'd0, !reset && (m_active || (!(e_done || e_error) && (req_read || req_write)))});
        end
    end

    // ---------------- directed transaction recorder ----------------
    logic [31:0] s_req_data_in [64];
    logic [31:0] s_mem_data_out[64];
    logic [29:0] s_mem_address [64];
    logic [3:0]  s_mem_strobes [64];
    bit          s_busy[64], s_done[64], s_error[64], s_mem_read[64], s_mem_write[64];

    // Cycle 0 presents the request; mem_ready is high from cycle ready_from;
    // reset is high during cycle reset_at; outputs are sampled mid-cycle.
    task automatic run_txn(input bit rd, input bit wr, input bit berr,
                           input logic [29:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] rdata,
                           input int ready_from, input int reset_at, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock); #1;
            if (c == 0) begin
                req_address      = addr;
                req_data_out     = data;
                req_data_strobes = strb;
                req_bus_error    = berr;
                req_read         = rd;
                req_write        = wr;
            end else if (e_done || e_error) begin
                req_read = 1'b0; req_write = 1'b0; req_bus_error = 1'b0;
            end
            reset = (c == reset_at);
            if (c == reset_at) begin
                req_read = 1'b0; req_write = 1'b0;
            end
            mem_ready   = (c >= ready_from);
            mem_data_in = rdata;
            @(negedge clock);
            s_req_data_in[c]  = req_data_in;
            s_mem_data_out[c] = mem_data_out;
            s_mem_address[c]  = mem_address;
            s_mem_strobes[c]  = mem_strobes;
            s_busy[c]         = busy;
            s_done[c]         = done;
            s_error[c]        = error;
            s_mem_read[c]     = mem_read;
            s_mem_write[c]    = mem_write;
        end
        @(posedge clock); #1;
        req_read = 1'b0; req_write = 1'b0; req_bus_error = 1'b0;
        mem_ready = 1'b0; reset = 1'b0;
    endtask

    function automatic bit any_set(input bit a[64], input int n);
        bit r = 1'b0;
        for (int i = 0; i < n; i++) r |= a[i];
        return r;
    endfunction

    initial begin
        // Reset state, with a request present to show busy is forced low.
        reset = 1'b1;
        req_read = 1'b1;
        @(posedge clock); #1;
        check_en = 1'b1;
        @(negedge clock);
        chk("rst_mem_data_out", mem_data_out, 32'hffff_ffff);
        chk("rst_req_data_in", req_data_in, 32'hffff_ffff);
        chk("rst_mem_address", {2'b00, mem_address}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; req_read = 1'b0;
        repeat (2) @(posedge clock);

        // Read, ready tied high.
        run_txn(1, 0, 0, 30'h0123_4567, 32'h0, 4'hf, 32'h1234_5678, 0, -1, 6);
        chk("rd_busy_c0", {31'd0, s_busy[0]}, 32'd1);
        chk("rd_mem_read_c1", {31'd0, s_mem_read[1]}, 32'd1);
        chk("rd_mem_read_c2", {31'd0, s_mem_read[2]}, 32'd1);
        chk("rd_mem_read_c3", {31'd0, s_mem_read[3]}, 32'd0);
        chk("rd_done_c2", {31'd0, s_done[2]}, 32'd0);
        chk("rd_done_c3", {31'd0, s_done[3]}, 32'd1);
        chk("rd_busy_c3", {31'd0, s_busy[3]}, 32'd0);
        chk("rd_data_c3", s_req_data_in[3], 32'h1234_5678);

        // Write with ready arriving in cycle 4.
        run_txn(0, 1, 0, 30'h0000_0040, 32'hbeef_ffff, 4'b1100, 32'hdead_0001, 4, -1, 8);
        chk("wr_addr_c4", {2'b00, s_mem_address[4]}, 32'h40);
        chk("wr_strb_c4", {28'd0, s_mem_strobes[4]}, 32'hc);
        chk("wr_data_c4", s_mem_data_out[4], 32'hbeef_ffff);
        chk("wr_write_c4", {31'd0, s_mem_write[4]}, 32'd1);
        chk("wr_done_c4", {31'd0, s_done[4]}, 32'd0);
        chk("wr_done_c5", {31'd0, s_done[5]}, 32'd1);
        chk("wr_write_c5", {31'd0, s_mem_write[5]}, 32'd0);
        chk("wr_data_c5", s_mem_data_out[5], 32'hffff_ffff);
        chk("wr_rdata_c5", s_req_data_in[5], 32'h1234_5678);

        // Upstream bus error with a read.
        run_txn(1, 0, 1, 30'h5, 32'h0, 4'hf, 32'h0, 0, -1, 4);
        chk("berr_error_c1", {31'd0, s_error[1]}, 32'd1);
        chk("berr_no_read", {31'd0, any_set(s_mem_read, 4)}, 32'd0);
        chk("berr_busy_c0", {31'd0, s_busy[0]}, 32'd1);
        chk("berr_busy_c1", {31'd0, s_busy[1]}, 32'd0);

        // Read and write together.
        run_txn(1, 1, 0, 30'h6, 32'h0, 4'hf, 32'h0, 0, -1, 4);
        chk("both_error_c1", {31'd0, s_error[1]}, 32'd1);
        chk("both_no_strobe", {31'd0, any_set(s_mem_read, 4) | any_set(s_mem_write, 4)}, 32'd0);

        // Device never acknowledges.
`ifdef BUS_TIMEOUT_EN
        run_txn(1, 0, 0, 30'h7, 32'h0, 4'hf, 32'h0, 1000, -1, 24);
        chk("to_error_c17", {31'd0, s_error[17]}, 32'd0);
        chk("to_error_c18", {31'd0, s_error[18]}, 32'd1);
        chk("to_read_c17", {31'd0, s_mem_read[17]}, 32'd1);
        chk("to_read_c18", {31'd0, s_mem_read[18]}, 32'd0);
`else
        run_txn(1, 0, 0, 30'h7, 32'h0, 4'hf, 32'h0, 1000, 35, 40);
        chk("hang_busy_c34", {31'd0, s_busy[34]}, 32'd1);
        chk("hang_read_c34", {31'd0, s_mem_read[34]}, 32'd1);
        chk("hang_no_error", {31'd0, any_set(s_error, 35)}, 32'd0);
`endif

        // Reset during cycle 2 of a read, then a clean read.
        run_txn(1, 0, 0, 30'h8, 32'h0, 4'hf, 32'h0, 1000, 2, 8);
        chk("rst_read_c2", {31'd0, s_mem_read[2]}, 32'd1);
        chk("rst_busy_c2", {31'd0, s_busy[2]}, 32'd0);
        chk("rst_read_c3", {31'd0, s_mem_read[3]}, 32'd0);
        chk("rst_no_pulse", {31'd0, any_set(s_done, 8) | any_set(s_error, 8)}, 32'd0);
        run_txn(1, 0, 0, 30'h9, 32'h0, 4'hf, 32'hcafe_0009, 0, -1, 6);
        chk("post_rst_done_c3", {31'd0, s_done[3]}, 32'd1);
        chk("post_rst_data_c3", s_req_data_in[3], 32'hcafe_0009);

        // Randomized traffic checked only by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            reset       = ($urandom_range(0, 299) == 0);
            mem_ready   = $urandom_range(0, 1) == 1;
            mem_data_in = $urandom;
            if (e_done || e_error) begin
                req_read = 1'b0; req_write = 1'b0; req_bus_error = 1'b0;
            end else if (m_active) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_address      = 30'($urandom);
                    req_data_out     = $urandom;
                    req_data_strobes = 4'($urandom);
                    req_read         = $urandom_range(0, 1) == 1;
                    req_write        = $urandom_range(0, 1) == 1;
                    req_bus_error    = $urandom_range(0, 1) == 1;
                end
            end else if (!req_read && !req_write && $urandom_range(0, 2) == 0) begin
                int kind;
                kind = $urandom_range(0, 9);
                req_address      = 30'($urandom);
                req_data_out     = $urandom;
                req_data_strobes = 4'($urandom);
                req_bus_error    = (kind == 1);
                req_read         = (kind <= 1) || (kind >= 6);
                req_write        = (kind == 0) || (kind >= 2 && kind <= 5);
            end
        end
        @(posedge clock); #1;
        reset = 1'b0; req_read = 1'b0; req_write = 1'b0;
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
